// File: rtl/pool2d_stream.sv
// Streaming 2-D max/average pooling over a raster pixel stream with KERNEL-row line buffer.
// Latency: one cycle from the accept that completes a window to valid_out.
// Backpressure: ready_in = !valid_out || ready_out; a stalled result holds and blocks new pixels.
module pool2d_stream #(
    parameter int WIDTH  = 26,
    parameter int HEIGHT = 26,
    parameter int DATA_W = 8,
    parameter int KERNEL = 2,
    parameter int STRIDE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              last_out
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam int PW = $clog2(KERNEL);
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int AW = DATA_W + $clog2(KERNEL * KERNEL);
    localparam int OW = (WIDTH - KERNEL) / STRIDE + 1;
    localparam int OH = (HEIGHT - KERNEL) / STRIDE + 1;

    localparam logic [XW-1:0] X_MAX  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_K    = XW'(KERNEL - 1);
    localparam logic [YW-1:0] Y_K    = YW'(KERNEL - 1);
    localparam logic [XW-1:0] X_LAST = XW'(KERNEL - 1 + (OW - 1) * STRIDE);
    localparam logic [YW-1:0] Y_LAST = YW'(KERNEL - 1 + (OH - 1) * STRIDE);
    localparam logic [PW-1:0] P_MAX  = PW'(KERNEL - 1);
    localparam logic [SW-1:0] S_MAX  = SW'(STRIDE - 1);
    localparam logic [AW-1:0] DIV    = AW'(KERNEL * KERNEL);

    // Position of the next pixel, line-buffer row being written, and stride phases.
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [PW-1:0] wr_row;
    logic [SW-1:0] sx;
    logic [SW-1:0] sy;
    logic          mode_q;

    // Storage that is fully overwritten before use, so it carries no reset.
    logic [DATA_W-1:0] lb      [KERNEL][WIDTH];
    logic [DATA_W-1:0] win     [KERNEL][KERNEL];
    logic [DATA_W-1:0] win_nxt [KERNEL][KERNEL];

    logic [AW-1:0]     sum;
    logic [DATA_W-1:0] mx;
    logic [DATA_W-1:0] pool_res;

    logic accept;
    logic row_end;
    logic frame_end;
    logic fire;
    logic is_last;

    assign ready_in  = !valid_out || ready_out;
    assign accept    = valid_in && ready_in;
    assign row_end   = (x == X_MAX);
    assign frame_end = row_end && (y == Y_MAX);
    assign fire      = accept && (x >= X_K) && (y >= Y_K) && (sx == '0) && (sy == '0);
    assign is_last   = (x == X_LAST) && (y == Y_LAST);

    // Window after this accept: shift left, right column from older buffer rows plus data_in.
    // The oldest row sits just after the write pointer in circular order.
    always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
        end
        for (int r = 0; r < KERNEL - 1; r++) begin
            win_nxt[r][KERNEL-1] = lb[PW'((int'(wr_row) + 1 + r) % KERNEL)][x];
        end
        win_nxt[KERNEL-1][KERNEL-1] = data_in;
    end

    // Max and floor-average of the completed window; sum is wide enough to never overflow.
    always_comb begin
        sum = '0;
        mx  = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                sum = sum + AW'(win_nxt[r][c]);
                if (win_nxt[r][c] > mx) begin
                    mx = win_nxt[r][c];
                end
            end
        end
        pool_res = mode_q ? DATA_W'(sum / DIV) : mx;
    end

    // Raster position, stride phase, buffer row pointer and per-frame mode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            wr_row <= '0;
            sx     <= '0;
            sy     <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            if (x == '0 && y == '0) begin
                mode_q <= mode;
            end
            if (row_end) begin
                x      <= '0;
                sx     <= '0;
                wr_row <= (wr_row == P_MAX) ? '0 : wr_row + 1'b1;
                if (frame_end) begin
                    y  <= '0;
                    sy <= '0;
                end else begin
                    y <= y + 1'b1;
                    if (y >= Y_K) begin
                        sy <= (sy == S_MAX) ? '0 : sy + 1'b1;
                    end else begin
                        sy <= '0;
                    end
                end
            end else begin
                x <= x + 1'b1;
                if (x >= X_K) begin
                    sx <= (sx == S_MAX) ? '0 : sx + 1'b1;
                end else begin
                    sx <= '0;
                end
            end
        end
    end

    // Line buffer write and window shift on every accepted pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[wr_row][x] <= data_in;
            win           <= win_nxt;
        end
    end

    // Output register: load on a completed window, otherwise drop valid once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
        end else if (fire) begin
            valid_out <= 1'b1;
            data_out  <= pool_res;
            last_out  <= is_last;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool2d_stream.sv
module tb_pool2d_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_mode, a_valid_in, a_ready_in, a_valid_out, a_ready_out, a_last_out;
    logic [7:0] a_data_in, a_data_out;
    logic       b_mode, b_valid_in, b_ready_in, b_valid_out, b_ready_out, b_last_out;
    logic [7:0] b_data_in, b_data_out;

    pool2d_stream #(.WIDTH(4), .HEIGHT(4), .DATA_W(8), .KERNEL(2), .STRIDE(2)) dut_a (
        .clk(clk), .rst(rst), .mode(a_mode),
        .valid_in(a_valid_in), .ready_in(a_ready_in), .data_in(a_data_in),
        .valid_out(a_valid_out), .ready_out(a_ready_out), .data_out(a_data_out),
        .last_out(a_last_out)
    );

    pool2d_stream #(.WIDTH(4), .HEIGHT(4), .DATA_W(8), .KERNEL(3), .STRIDE(1)) dut_b (
        .clk(clk), .rst(rst), .mode(b_mode),
        .valid_in(b_valid_in), .ready_in(b_ready_in), .data_in(b_data_in),
        .valid_out(b_valid_out), .ready_out(b_ready_out), .data_out(b_data_out),
        .last_out(b_last_out)
    );

    int errors = 0;
    int checks = 0;

    // Expected {last, data} per output, pushed when the stimulus is issued.
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    logic [8:0] e_a, e_b;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitors: compare on every completed output handshake.
    always @(negedge clk) begin
        if (!rst && a_valid_out && a_ready_out) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got data=%0d last=%0d, expected no output", a_data_out, a_last_out);
            end else begin
                e_a = exp_a.pop_front();
                checks++;
                if ({a_last_out, a_data_out} !== e_a) begin
                    errors++;
                    $display("FAIL a_out: got data=%0d last=%0d, expected data=%0d last=%0d",
                             a_data_out, a_last_out, e_a[7:0], e_a[8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_valid_out && b_ready_out) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got data=%0d last=%0d, expected no output", b_data_out, b_last_out);
            end else begin
                e_b = exp_b.pop_front();
                checks++;
                if ({b_last_out, b_data_out} !== e_b) begin
                    errors++;
                    $display("FAIL b_out: got data=%0d last=%0d, expected data=%0d last=%0d",
                             b_data_out, b_last_out, e_b[7:0], e_b[8]);
                end
            end
        end
    end

    task automatic push_a(input int v0, input int v1, input int v2, input int v3);
        exp_a.push_back({1'b0, 8'(v0)});
        exp_a.push_back({1'b0, 8'(v1)});
        exp_a.push_back({1'b0, 8'(v2)});
        exp_a.push_back({1'b1, 8'(v3)});
    endtask

    task automatic push_b(input int v0, input int v1, input int v2, input int v3);
        exp_b.push_back({1'b0, 8'(v0)});
        exp_b.push_back({1'b0, 8'(v1)});
        exp_b.push_back({1'b0, 8'(v2)});
        exp_b.push_back({1'b1, 8'(v3)});
    endtask

    task automatic send_a(input logic [7:0] pix, input logic md, input int gap);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        a_data_in  = pix;
        a_mode     = md;
        a_valid_in = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = a_ready_in;
            @(posedge clk);
            #1;
            n++;
        end
        a_valid_in = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL a_send_timeout: pixel %0d not accepted within %0d cycles", pix, n);
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_b(input logic [7:0] pix, input logic md);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        b_data_in  = pix;
        b_mode     = md;
        b_valid_in = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = b_ready_in;
            @(posedge clk);
            #1;
            n++;
        end
        b_valid_in = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL b_send_timeout: pixel %0d not accepted within %0d cycles", pix, n);
        end
    endtask

    // 4x4 frame: ramp 0..15 or all 255; mode md0 for first half, md_mid for second half.
    task automatic frame_a(input logic md0, input logic md_mid, input bit rgap, input bit all_max);
        for (int i = 0; i < 16; i++) begin
            send_a(all_max ? 8'd255 : 8'(i), (i < 8) ? md0 : md_mid,
                   rgap ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic frame_b(input logic md);
        for (int i = 0; i < 16; i++) begin
            send_b(8'(i), md);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d outputs still pending, expected 0",
                     exp_a.size(), exp_b.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_mode = 1'b0; a_valid_in = 1'b0; a_data_in = '0; a_ready_out = 1'b1;
        b_mode = 1'b0; b_valid_in = 1'b0; b_data_in = '0; b_ready_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_valid", int'(a_valid_out), 0);
        check("rst_a_data",  int'(a_data_out), 0);
        check("rst_a_last",  int'(a_last_out), 0);
        check("rst_b_valid", int'(b_valid_out), 0);
        check("rst_b_data",  int'(b_data_out), 0);
        check("rst_b_last",  int'(b_last_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_a_ready_in", int'(a_ready_in), 1);
        check("rst_b_ready_in", int'(b_ready_in), 1);
        @(posedge clk);
        #1;

        // K=2 S=2 max then average.
        push_a(5, 7, 13, 15);
        frame_a(1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        push_a(2, 4, 10, 12);
        frame_a(1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // K=3 S=1 max then average (divide by 9).
        push_b(10, 11, 14, 15);
        frame_b(1'b0);
        drain();
        push_b(5, 6, 9, 10);
        frame_b(1'b1);
        drain();

        // Saturated pixels in average mode: sum must not overflow.
        push_a(255, 255, 255, 255);
        frame_a(1'b1, 1'b1, 1'b0, 1'b1);
        drain();

        // Downstream stall for 3 cycles on the first result.
        push_a(5, 7, 13, 15);
        fork
            frame_a(1'b0, 1'b0, 1'b0, 1'b0);
            begin
                int n;
                n = 0;
                while (!a_valid_out && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("stall_first_valid", int'(a_valid_out), 1);
                a_ready_out = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_data",     int'(a_data_out), 5);
                    check("stall_valid",    int'(a_valid_out), 1);
                    check("stall_last",     int'(a_last_out), 0);
                    check("stall_ready_in", int'(a_ready_in), 0);
                    @(posedge clk);
                    #1;
                end
                a_ready_out = 1'b1;
            end
        join
        drain();

        // Reset after 6 pixels; the pending result of the aborted frame is never taken.
        a_ready_out = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_a(8'(i), 1'b0, 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_ready_out = 1'b1;
        check("midrst_valid", int'(a_valid_out), 0);
        @(negedge clk);
        check("midrst_ready_in", int'(a_ready_in), 1);
        @(posedge clk);
        #1;
        push_a(5, 7, 13, 15);
        frame_a(1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Back-to-back frames with mode toggled mid-frame.
        push_a(5, 7, 13, 15);
        push_a(2, 4, 10, 12);
        frame_a(1'b0, 1'b1, 1'b0, 1'b0);
        frame_a(1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        check("a_queue_empty", exp_a.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
